// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bridge
//  Description : JAM-1 memory bridge. Runs one byte access on the external
//                memory port with a req/ack handshake, holds the pipeline
//                with busy, aborts on a wait-state timeout and presents
//                captured read data for assertion onto the main bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              MemBridge_Load,
    input  logic              MemBridge_Direction,
    input  logic              MemBridge_Assert,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] mainbus_in,
    output logic [DATA_W-1:0] mainbus_out,
    output logic              mainbus_oe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              timeout_err
);

    // Wait counter is wide enough to hold TIMEOUT; at least one bit so a
    // disabled timeout (TIMEOUT = 0) still yields a legal vector.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [0:0]       c_IDLE       = 1'b0;
    localparam logic [0:0]       c_ACCESS     = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_LIMIT  = CNT_W'(TIMEOUT);
    localparam logic             c_TIMEOUT_EN = (TIMEOUT != 0);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_inc;
    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_rdata;
    logic              r_timeout_err;

    // Counter value after this cycle's wait; saturates instead of wrapping.
    assign w_wait_cnt_inc = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt
                                                      : r_wait_cnt + CNT_W'(1);

    // The counter starts at 0 in the first request cycle, so the incremented
    // value reaching TIMEOUT marks the TIMEOUT-th request cycle. An ack in
    // that same cycle takes priority over the abort.
    assign w_start = (r_state == c_IDLE) && MemBridge_Load;
    assign w_done  = (r_state == c_ACCESS) && mem_ack;
    assign w_abort = c_TIMEOUT_EN && (r_state == c_ACCESS) && !mem_ack &&
                     (w_wait_cnt_inc == c_CNT_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start from IDLE, leave ACCESS on ack or abort.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (w_start) w_state_next = c_ACCESS;
            c_ACCESS: if (w_done || w_abort) w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Access fields, wait counter, read-data capture and error pulse.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_rdata       <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_abort;
            if (w_start) begin
                r_addr     <= addr_in;
                r_wdata    <= mainbus_in;
                r_we       <= MemBridge_Direction;
                r_wait_cnt <= '0;
            end else if (r_state == c_ACCESS && !mem_ack) begin
                r_wait_cnt <= w_wait_cnt_inc;
            end
            if (w_done && !r_we) begin
                r_rdata <= mem_rdata;
            end else if (w_abort && !r_we) begin
                r_rdata <= '1;
            end
        end
    end

    assign mem_req     = (r_state == c_ACCESS);
    assign busy        = (r_state == c_ACCESS);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mainbus_out = r_rdata;
    assign timeout_err = r_timeout_err;
    assign mainbus_oe  = MemBridge_Assert;

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bridge
//  Description : Self-checking bench for mem_bridge. A transaction-level
//                model predicts every output each cycle; directed scenarios
//                add hand-computed literal expectations, then a randomized
//                phase exercises loads, acks, timeouts and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bridge;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_in;
    logic              MemBridge_Load;
    logic              MemBridge_Direction;
    logic              MemBridge_Assert;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] mainbus_in;
    logic [DATA_W-1:0] mainbus_out;
    logic              mainbus_oe;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              timeout_err;

    always #5 clk = ~clk;

    mem_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset_in           (reset_in),
        .MemBridge_Load     (MemBridge_Load),
        .MemBridge_Direction(MemBridge_Direction),
        .MemBridge_Assert   (MemBridge_Assert),
        .addr_in            (addr_in),
        .mainbus_in         (mainbus_in),
        .mainbus_out        (mainbus_out),
        .mainbus_oe         (mainbus_oe),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: is an access outstanding, what was latched,
    // how many request cycles it has used, and what the bus register holds.
    logic              m_active = 1'b0;
    logic              m_we     = 1'b0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_wdata  = '0;
    logic [DATA_W-1:0] m_out    = '0;
    logic              m_err    = 1'b0;
    int                m_reqs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_step();
        m_err = 1'b0;
        if (reset_in) begin
            m_active = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_out    = '0;   m_reqs = 0;
        end else if (!m_active) begin
            if (MemBridge_Load) begin
                m_active = 1'b1;
                m_addr   = addr_in;
                m_wdata  = mainbus_in;
                m_we     = MemBridge_Direction;
                m_reqs   = 1;
            end
        end else if (mem_ack) begin
            m_active = 1'b0;
            if (!m_we) m_out = mem_rdata;
        end else if (TIMEOUT != 0 && m_reqs >= TIMEOUT) begin
            m_active = 1'b0;
            m_err    = 1'b1;
            if (!m_we) m_out = 8'hFF;
        end else begin
            m_reqs++;
        end
    endtask

    task automatic compare_all();
        chk("req",       mem_req,     m_active);
        chk("busy",      busy,        m_active);
        chk("we",        mem_we,      m_we);
        chk("addr",      mem_addr,    m_addr);
        chk("wdata",     mem_wdata,   m_wdata);
        chk("bus_out",   mainbus_out, m_out);
        chk("tout_err",  timeout_err, m_err);
        chk("bus_oe",    mainbus_oe,  MemBridge_Assert);
    endtask

    // One clock: model follows the edge, outputs are checked 4 time units later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #4;
        compare_all();
    endtask

    task automatic quiet();
        reset_in = 1'b0; MemBridge_Load = 1'b0; MemBridge_Assert = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d, input logic dir);
        MemBridge_Load = 1'b1; addr_in = a; mainbus_in = d; MemBridge_Direction = dir;
    endtask

    initial begin
        int req_cycles;
        int guard;
        int ack_pct;

        reset_in = 1'b1; MemBridge_Load = 1'b0; MemBridge_Direction = 1'b0;
        MemBridge_Assert = 1'b1; addr_in = '0; mainbus_in = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset state; oe follows Assert even in reset.
        tick(); tick();
        chk("rst_req", mem_req, 0);
        chk("rst_out", mainbus_out, 0);
        chk("rst_oe", mainbus_oe, 1);
        quiet();
        tick();

        // Read, zero wait states.
        load(16'h1234, 8'h00, 1'b0);
        tick();
        MemBridge_Load = 1'b0;
        chk("rd0_addr", mem_addr, 16'h1234);
        chk("rd0_we", mem_we, 0);
        chk("rd0_busy", busy, 1);
        mem_ack = 1'b1; mem_rdata = 8'hA5; MemBridge_Assert = 1'b1;
        tick();
        mem_ack = 1'b0; MemBridge_Assert = 1'b0;
        chk("rd0_data", mainbus_out, 8'hA5);
        chk("rd0_busy_low", busy, 0);
        tick();

        // Write with three wait states: ack on the fourth request cycle.
        load(16'h0040, 8'h3C, 1'b1);
        tick();
        MemBridge_Load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("wr_req", mem_req, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_wdata", mem_wdata, 8'h3C);
            if (i == 4) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("wr_done", mem_req, 0);
        chk("wr_out_kept", mainbus_out, 8'hA5);
        tick();

        // Read timeout with no ack.
        load(16'h0ABC, 8'h00, 1'b0);
        tick();
        MemBridge_Load = 1'b0;
        req_cycles = 0; guard = 0;
        while (mem_req === 1'b1 && guard < 100) begin
            req_cycles++; guard++;
            tick();
        end
        chk("to_req_cycles", req_cycles, 15);
        chk("to_err", timeout_err, 1);
        chk("to_out", mainbus_out, 8'hFF);
        chk("to_busy", busy, 0);
        tick();
        chk("to_err_once", timeout_err, 0);

        // Ack arriving in the would-be abort cycle completes normally.
        load(16'h0ABD, 8'h00, 1'b0);
        tick();
        MemBridge_Load = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        chk("ack15_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0;
        chk("ack15_err", timeout_err, 0);
        chk("ack15_out", mainbus_out, 8'h5A);
        tick();

        // Load while busy is ignored.
        load(16'h1111, 8'h00, 1'b0);
        tick();
        load(16'hBEEF, 8'h00, 1'b0);
        tick();
        MemBridge_Load = 1'b0;
        chk("lwb_addr", mem_addr, 16'h1111);
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ack = 1'b0;
        chk("lwb_out", mainbus_out, 8'hC3);
        tick();
        chk("lwb_single", mem_req, 0);

        // Reset in the middle of an access.
        load(16'h4321, 8'h00, 1'b0);
        tick();
        MemBridge_Load = 1'b0;
        tick(); tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("rma_req", mem_req, 0);
        chk("rma_addr", mem_addr, 0);
        chk("rma_err", timeout_err, 0);
        chk("rma_out", mainbus_out, 0);
        mem_ack = 1'b1; mem_rdata = 8'h66;
        tick();
        mem_ack = 1'b0;
        chk("rma_late_ack", mainbus_out, 0);

        // Back-to-back read then write.
        load(16'h2222, 8'h00, 1'b0);
        tick();
        MemBridge_Load = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        chk("b2b_gap", mem_req, 0);
        load(16'h3333, 8'h99, 1'b1);
        tick();
        MemBridge_Load = 1'b0;
        chk("b2b_req2", mem_req, 1);
        chk("b2b_wdata", mem_wdata, 8'h99);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("b2b_out", mainbus_out, 8'h77);
        chk("b2b_done", busy, 0);

        // Randomized traffic with varying ack likelihood (0% forces timeouts).
        ack_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       ack_pct = 0;
                    1:       ack_pct = 10;
                    2:       ack_pct = 40;
                    default: ack_pct = 90;
                endcase
            end
            reset_in            = ($urandom_range(0, 299) == 0);
            MemBridge_Load      = ($urandom_range(0, 3) == 0);
            MemBridge_Direction = $urandom_range(0, 1) == 1;
            MemBridge_Assert    = $urandom_range(0, 1) == 1;
            addr_in             = 16'($urandom);
            mainbus_in          = 8'($urandom);
            mem_rdata           = 8'($urandom);
            mem_ack             = ($urandom_range(0, 99) < ack_pct);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
